// File: rtl/systolic_pkg.sv
`default_nettype none
//==============================================================================
// Package : systolic_pkg
// Shared defaults, reader FSM encoding and lane-mask helper for RAM_O access.
// Rev     : 1.0
//==============================================================================
package systolic_pkg;

    localparam int ARRAY_M_DEFAULT    = 8;
    localparam int RAM_O_SIZE_DEFAULT = 256;
    localparam int DATA_WIDTH_DEFAULT = 32;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_READ   = 2'd1,
        S_DRAIN  = 2'd2,
        S_FINISH = 2'd3
    } rd_state_t;

    // Bit i set when lane i is below the active column count.
    function automatic logic [ARRAY_M_DEFAULT-1:0] lane_mask(input int unsigned n);
        logic [ARRAY_M_DEFAULT-1:0] m;
        m = '0;
        for (int unsigned i = 0; i < ARRAY_M_DEFAULT; i++) begin
            if (i < n) m = m | (ARRAY_M_DEFAULT'(1) << i);
        end
        return m;
    endfunction

endpackage
`default_nettype wire

// File: rtl/skid_fifo2.sv
`default_nettype none
//==============================================================================
// Module : skid_fifo2
// Two-entry registered FIFO; output valid depends only on stored occupancy.
// Rev    : 1.0
//==============================================================================
module skid_fifo2 #(
    parameter int WIDTH = 257
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_pop,
    output logic             o_valid,
    output logic [WIDTH-1:0] o_data,
    output logic [1:0]       o_count
);

    logic [WIDTH-1:0] r_head;
    logic [WIDTH-1:0] r_tail;
    logic [1:0]       r_count;

    logic w_pop;
    logic w_push;

    assign o_valid = (r_count != 2'd0);
    assign o_data  = o_valid ? r_head : '0;
    assign o_count = r_count;
    assign w_pop   = i_pop & o_valid;
    assign w_push  = i_push & ((r_count != 2'd2) | w_pop);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= 2'd0;
        end else begin
            case ({w_push, w_pop})
                2'b10: begin
                    if (r_count == 2'd0) r_head <= i_data;
                    else                 r_tail <= i_data;
                    r_count <= r_count + 2'd1;
                end
                2'b01: begin
                    r_head  <= r_tail;
                    r_count <= r_count - 2'd1;
                end
                2'b11: begin
                    // Simultaneous push/pop keeps occupancy; the new word lands behind any survivor.
                    if (r_count == 2'd1) begin
                        r_head <= i_data;
                    end else begin
                        r_head <= r_tail;
                        r_tail <= i_data;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/o_buffer_reader.sv
`default_nettype none
//==============================================================================
// Module : o_buffer_reader
// Reads RAM_O one row per cycle across all banks and streams masked rows out.
// Rev    : 1.0
//==============================================================================
module o_buffer_reader
    import systolic_pkg::*;
#(
    parameter int RAM_O_SIZE     = RAM_O_SIZE_DEFAULT,
    parameter int ARRAY_M        = ARRAY_M_DEFAULT,
    parameter int DATA_WIDTH     = DATA_WIDTH_DEFAULT,
    parameter int ADDR_WIDTH     = $clog2(RAM_O_SIZE),
    parameter int ADDR_SET_WIDTH = ADDR_WIDTH * ARRAY_M,
    parameter int DATA_SET_WIDTH = DATA_WIDTH * ARRAY_M
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      start,
    input  logic [ADDR_WIDTH-1:0]     base_addr,
    input  logic [ADDR_WIDTH:0]       depth,
    input  logic [$clog2(ARRAY_M):0]  num_cols,
    output logic                      busy,
    output logic                      done,
    output logic [ADDR_SET_WIDTH-1:0] rd_addr_set,
    output logic [ARRAY_M-1:0]        rd_en_set,
    input  logic [DATA_SET_WIDTH-1:0] rd_data_set,
    output logic                      m_valid,
    input  logic                      m_ready,
    output logic [DATA_SET_WIDTH-1:0] m_data,
    output logic [ARRAY_M-1:0]        m_keep,
    output logic                      m_last
);

    localparam int NCOL_WIDTH = $clog2(ARRAY_M) + 1;
    localparam logic [NCOL_WIDTH-1:0] c_ncol_max = NCOL_WIDTH'(ARRAY_M);
    localparam logic [ADDR_WIDTH:0]   c_row_one  = {{ADDR_WIDTH{1'b0}}, 1'b1};

    rd_state_t             r_state;
    logic [ADDR_WIDTH-1:0] r_base;
    logic [ADDR_WIDTH:0]   r_depth;
    logic [ADDR_WIDTH:0]   r_row;
    logic [ARRAY_M-1:0]    r_mask;
    logic                  r_inflight;
    logic                  r_inflight_last;
    logic                  r_busy;
    logic                  r_done;

    logic [NCOL_WIDTH-1:0]     w_ncols_clamped;
    logic [ARRAY_M-1:0]        w_start_mask;
    logic                      w_zero_run;
    logic [1:0]                w_fifo_count;
    logic                      w_fifo_valid;
    logic [DATA_SET_WIDTH:0]   w_fifo_data;
    logic                      w_pop;
    logic [2:0]                w_occ;
    logic                      w_issue;
    logic                      w_last_issue;
    logic                      w_drain_done;
    logic [ADDR_WIDTH-1:0]     w_rd_addr;
    logic [DATA_SET_WIDTH-1:0] w_masked_data;

    assign w_ncols_clamped = (num_cols > c_ncol_max) ? c_ncol_max : num_cols;
    assign w_zero_run      = (depth == '0) || (w_ncols_clamped == '0);

    if (ARRAY_M == ARRAY_M_DEFAULT) begin : g_mask_pkg
        assign w_start_mask = lane_mask(32'(w_ncols_clamped));
    end else begin : g_mask_cmp
        for (genvar i = 0; i < ARRAY_M; i++) begin : g_lane
            assign w_start_mask[i] = (32'(i) < 32'(w_ncols_clamped));
        end
    end

    // Occupancy counts reads still in flight so a stalled sink never overflows the FIFO.
    assign w_pop        = w_fifo_valid & m_ready;
    assign w_occ        = 3'(w_fifo_count) + 3'(r_inflight) - 3'(w_pop);
    assign w_issue      = (r_state == S_READ) && (r_row < r_depth) && (w_occ < 3'd2);
    assign w_last_issue = w_issue && (r_row == r_depth - c_row_one);
    assign w_drain_done = !r_inflight &&
                          ((w_fifo_count == 2'd0) || ((w_fifo_count == 2'd1) && w_pop));
    assign w_rd_addr    = r_base + r_row[ADDR_WIDTH-1:0];
    assign rd_en_set    = w_issue ? r_mask : '0;

    for (genvar i = 0; i < ARRAY_M; i++) begin : g_bank
        assign rd_addr_set[i*ADDR_WIDTH +: ADDR_WIDTH] = rd_en_set[i] ? w_rd_addr : '0;
        assign w_masked_data[i*DATA_WIDTH +: DATA_WIDTH] =
            r_mask[i] ? rd_data_set[i*DATA_WIDTH +: DATA_WIDTH] : '0;
    end

    skid_fifo2 #(
        .WIDTH(DATA_SET_WIDTH + 1)
    ) u_skid (
        .clk     (clk),
        .reset   (reset),
        .i_push  (r_inflight),
        .i_data  ({r_inflight_last, w_masked_data}),
        .i_pop   (m_ready),
        .o_valid (w_fifo_valid),
        .o_data  (w_fifo_data),
        .o_count (w_fifo_count)
    );

    assign m_valid = w_fifo_valid;
    assign m_data  = w_fifo_data[DATA_SET_WIDTH-1:0];
    assign m_last  = w_fifo_data[DATA_SET_WIDTH];
    assign m_keep  = r_mask;
    assign busy    = r_busy;
    assign done    = r_done;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state         <= S_IDLE;
            r_base          <= '0;
            r_depth         <= '0;
            r_row           <= '0;
            r_mask          <= '0;
            r_inflight      <= 1'b0;
            r_inflight_last <= 1'b0;
            r_busy          <= 1'b0;
            r_done          <= 1'b0;
        end else begin
            r_inflight      <= w_issue;
            r_inflight_last <= w_last_issue;
            if (w_issue) r_row <= r_row + c_row_one;

            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_base  <= base_addr;
                        r_depth <= depth;
                        r_mask  <= w_start_mask;
                        r_row   <= '0;
                        r_busy  <= 1'b1;
                        r_state <= w_zero_run ? S_FINISH : S_READ;
                    end
                end
                S_READ: begin
                    if (w_last_issue) r_state <= S_DRAIN;
                end
                S_DRAIN: begin
                    // Leave as the final beat handshakes so done follows it directly.
                    if (w_drain_done) begin
                        r_done  <= 1'b1;
                        r_busy  <= 1'b0;
                        r_state <= S_FINISH;
                    end
                end
                S_FINISH: begin
                    // Empty runs arrive here with done not yet raised; raise it first.
                    if (r_done) begin
                        r_done  <= 1'b0;
                        r_state <= S_IDLE;
                    end else begin
                        r_done  <= 1'b1;
                        r_busy  <= 1'b0;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_o_buffer_reader.sv
`default_nettype none
//==============================================================================
// Module : tb_o_buffer_reader
// Scoreboard bench: RAM_O bank model, expected reads/beats queued at start.
// Rev    : 1.0
//==============================================================================
module tb_o_buffer_reader;

    localparam int M   = 8;
    localparam int AW  = 8;
    localparam int DW  = 32;
    localparam int DSW = DW * M;

    typedef struct {
        logic [DSW-1:0] data;
        logic [M-1:0]   keep;
        logic           last;
    } beat_t;

    typedef struct {
        logic [M-1:0]  en;
        logic [AW-1:0] addr;
    } rd_t;

    logic            clk = 1'b0;
    logic            reset;
    logic            start;
    logic [AW-1:0]   base_addr;
    logic [AW:0]     depth;
    logic [3:0]      num_cols;
    logic            busy;
    logic            done;
    logic [AW*M-1:0] rd_addr_set;
    logic [M-1:0]    rd_en_set;
    logic [DSW-1:0]  rd_data_set = '0;
    logic            m_valid;
    logic            m_ready;
    logic [DSW-1:0]  m_data;
    logic [M-1:0]    m_keep;
    logic            m_last;

    beat_t beat_q[$];
    rd_t   rd_q[$];

    int n_cmp = 0;
    int n_err = 0;
    int cyc = 0;
    int n0;
    int first_rden, first_valid, last_cyc, done_cyc, done_cnt, busy_cnt;
    int issued, popped, maxout;
    bit bp_mode = 1'b0;
    int bp_phase = 0;
    bit stall_prev = 1'b0;
    logic [DSW:0] prev_beat;

    o_buffer_reader dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .base_addr   (base_addr),
        .depth       (depth),
        .num_cols    (num_cols),
        .busy        (busy),
        .done        (done),
        .rd_addr_set (rd_addr_set),
        .rd_en_set   (rd_en_set),
        .rd_data_set (rd_data_set),
        .m_valid     (m_valid),
        .m_ready     (m_ready),
        .m_data      (m_data),
        .m_keep      (m_keep),
        .m_last      (m_last)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [DW-1:0] ram_word(input int lane, input logic [AW-1:0] addr);
        return {16'hC0DE, 4'(lane), 4'h0, addr};
    endfunction

    // Bank model: one-cycle read latency, disabled banks return all ones.
    always @(posedge clk) begin
        for (int i = 0; i < M; i++)
            rd_data_set[i*DW +: DW] <= rd_en_set[i] ? ram_word(i, rd_addr_set[i*AW +: AW])
                                                    : 32'hFFFF_FFFF;
    end

    always @(posedge clk) begin
        #1;
        if (bp_mode) begin
            m_ready  = (bp_phase == 0);
            bp_phase = (bp_phase + 1) % 3;
        end else begin
            m_ready = 1'b1;
        end
    end

    task automatic check_eq(input string tag, input logic [DSW:0] obs, input logic [DSW:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (reset) begin
            rd_t   r;
            beat_t b;
            if (busy) busy_cnt++;
            if (rd_en_set != '0) begin
                issued++;
                if (first_rden < 0) first_rden = cyc;
                if (rd_q.size() == 0) begin
                    check_eq("rd_unexpected", rd_en_set, 0);
                end else begin
                    r = rd_q.pop_front();
                    check_eq("rd_en", rd_en_set, r.en);
                    check_eq("rd_addr", rd_addr_set[AW-1:0], r.addr);
                end
            end
            if (m_valid && first_valid < 0) first_valid = cyc;
            if (stall_prev) begin
                check_eq("stall_valid", m_valid, 1);
                check_eq("stall_data", {m_last, m_data}, prev_beat);
            end
            if (m_valid && m_ready) begin
                popped++;
                if (beat_q.size() == 0) begin
                    check_eq("beat_unexpected", m_valid, 0);
                end else begin
                    b = beat_q.pop_front();
                    check_eq("beat_data", m_data, b.data);
                    check_eq("beat_keep", m_keep, b.keep);
                    check_eq("beat_last", m_last, b.last);
                end
                if (m_last) last_cyc = cyc;
            end
            stall_prev = m_valid && !m_ready;
            prev_beat  = {m_last, m_data};
            if (issued - popped > maxout) maxout = issued - popped;
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
                check_eq("busy_at_done", busy, 0);
            end
        end else begin
            stall_prev = 1'b0;
        end
    end

    task automatic do_start(input logic [AW-1:0] b, input logic [AW:0] d, input logic [3:0] nc);
        int    ncl;
        beat_t bt;
        rd_t   rr;
        ncl = (nc > 4'd8) ? 8 : int'(nc);
        @(posedge clk);
        #1;
        first_rden = -1; first_valid = -1; last_cyc = -1; done_cyc = -1;
        done_cnt = 0; busy_cnt = 0; issued = 0; popped = 0; maxout = 0;
        if (d != '0 && ncl != 0) begin
            for (int r = 0; r < int'(d); r++) begin
                rr.addr = AW'(int'(b) + r);
                rr.en   = '0;
                bt.data = '0;
                for (int i = 0; i < ncl; i++) begin
                    rr.en[i]             = 1'b1;
                    bt.data[i*DW +: DW]  = ram_word(i, rr.addr);
                end
                bt.keep = rr.en;
                bt.last = (r == int'(d) - 1);
                rd_q.push_back(rr);
                beat_q.push_back(bt);
            end
        end
        start = 1'b1; base_addr = b; depth = d; num_cols = nc;
        @(posedge clk);
        #1;
        n0    = cyc;
        start = 1'b0;
    endtask

    task automatic finish_run(input int budget);
        for (int k = 0; k < budget; k++) begin
            @(posedge clk);
            if (done_cnt > 0) break;
        end
        check_eq("done_seen", done_cnt > 0, 1);
        repeat (3) @(posedge clk);
        check_eq("done_once", done_cnt, 1);
        check_eq("beats_left", beat_q.size(), 0);
        check_eq("reads_left", rd_q.size(), 0);
    endtask

    task automatic check_idle_outputs(input string tag);
        check_eq({tag, "_busy"}, busy, 0);
        check_eq({tag, "_done"}, done, 0);
        check_eq({tag, "_rd_en"}, rd_en_set, 0);
        check_eq({tag, "_rd_addr"}, rd_addr_set, 0);
        check_eq({tag, "_m_valid"}, m_valid, 0);
        check_eq({tag, "_m_data"}, m_data, 0);
        check_eq({tag, "_m_keep"}, m_keep, 0);
        check_eq({tag, "_m_last"}, m_last, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b0; start = 1'b0; base_addr = '0; depth = '0; num_cols = '0; m_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_idle_outputs("reset");
        @(negedge clk) reset = 1'b1;

        // Basic drain with exact latency and back-to-back beats.
        do_start(8'd16, 9'd8, 4'd8);
        finish_run(60);
        check_eq("basic_first_rden", first_rden, n0);
        check_eq("basic_first_valid", first_valid, n0 + 2);
        check_eq("basic_last_beat", last_cyc, n0 + 9);
        check_eq("basic_done_cyc", done_cyc, n0 + 10);
        check_eq("basic_beats", popped, 8);

        do_start(8'd0, 9'd5, 4'd3);
        finish_run(60);
        check_eq("partial_beats", popped, 5);

        bp_mode = 1'b1; bp_phase = 0;
        do_start(8'd100, 9'd6, 4'd8);
        finish_run(200);
        check_eq("bp_beats", popped, 6);
        check_eq("bp_max_outstanding", maxout, 2);
        bp_mode = 1'b0;

        do_start(8'd254, 9'd4, 4'd8);
        finish_run(60);
        check_eq("wrap_beats", popped, 4);

        do_start(8'd10, 9'd0, 4'd8);
        finish_run(20);
        check_eq("d0_reads", issued, 0);
        check_eq("d0_valid", first_valid, -1);
        check_eq("d0_done_cyc", done_cyc, n0 + 1);
        check_eq("d0_busy_cycles", busy_cnt, 1);

        do_start(8'd10, 9'd4, 4'd0);
        finish_run(20);
        check_eq("c0_reads", issued, 0);
        check_eq("c0_done_cyc", done_cyc, n0 + 1);

        do_start(8'd32, 9'd3, 4'd12);
        finish_run(60);
        check_eq("clamp_beats", popped, 3);

        // Abort during the third beat.
        do_start(8'd50, 9'd8, 4'd8);
        for (int k = 0; k < 50; k++) begin
            @(posedge clk);
            if (popped >= 2) break;
        end
        #2 reset = 1'b0;
        #1;
        check_idle_outputs("abort");
        beat_q.delete();
        rd_q.delete();
        @(negedge clk) reset = 1'b1;
        repeat (10) @(posedge clk);
        check_eq("abort_no_done", done_cnt, 0);
        check_eq("abort_idle_busy", busy, 0);
        do_start(8'd8, 9'd4, 4'd5);
        finish_run(60);
        check_eq("fresh_first_valid", first_valid, n0 + 2);
        check_eq("fresh_beats", popped, 4);

        // A second start while busy must not disturb the first run.
        do_start(8'd40, 9'd8, 4'd8);
        repeat (3) @(posedge clk);
        #1;
        start = 1'b1; base_addr = 8'd100; depth = 9'd3; num_cols = 4'd2;
        @(posedge clk);
        #1 start = 1'b0;
        finish_run(60);
        repeat (20) @(posedge clk);
        check_eq("ignored_start_done", done_cnt, 1);
        check_eq("ignored_start_beats", popped, 8);
        check_eq("ignored_start_busy", busy, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
